// File: rtl/ncl_pkg.sv
// ----------------------------------------------------------------------------
// ncl_pkg
// Shared definitions for the dual-rail (NCL-style) ULA datapath stages.
//   - opcode constants of the ALU stage
//   - rail pair codes (NULL / logical 0 / logical 1 / illegal)
//   - stage state encoding
//   - vector encode/decode helpers between binary words and rail vectors.
//     They work on a fixed maximum width; callers zero-extend their operands
//     and keep only the low slice of the result.
// Rail packing: pair i occupies [2i+1:2i], [2i+1] = true rail, [2i] = false rail.
// ----------------------------------------------------------------------------
package ncl_pkg;

   localparam int DR_MAX_W = 64;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_0    = 2'b01;
   localparam logic [1:0] DR_1    = 2'b10;
   localparam logic [1:0] DR_ILL  = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   typedef logic [DR_MAX_W-1:0]   dr_word_t;
   typedef logic [2*DR_MAX_W-1:0] dr_rails_t;

   // Binary word -> rail vector (every pair becomes DR_0 or DR_1).
   function automatic dr_rails_t dr_encode(input dr_word_t v);
      dr_rails_t r;
      r = '0;
      for (int i = 0; i < DR_MAX_W; i++) begin
         r[2*i +: 2] = v[i] ? DR_1 : DR_0;
      end
      return r;
   endfunction

   // Rail vector -> binary word. Only meaningful on a complete DATA
   // wavefront, where the true rail alone carries the bit value.
   function automatic dr_word_t dr_decode(input dr_rails_t r);
      dr_word_t v;
      v = '0;
      for (int i = 0; i < DR_MAX_W; i++) begin
         v[i] = r[2*i+1];
      end
      return v;
   endfunction

endpackage

// File: rtl/ncl_compl_det.sv
// ----------------------------------------------------------------------------
// ncl_compl_det
// Completion detector over N dual-rail pairs.
// Ports:
//   rails    in  2*N  dual-rail vector, pair i = rails[2i+1:2i]
//   all_data out 1    every pair holds a logical 0 or 1
//   all_null out 1    every pair is NULL (00)
//   illegal  out 1    at least one pair is 11
// ----------------------------------------------------------------------------
module ncl_compl_det
   import ncl_pkg::*;
#(
   parameter int N = 1
) (
   input  logic [2*N-1:0] rails,
   output logic           all_data,
   output logic           all_null,
   output logic           illegal
);

   always_comb begin
      all_data = 1'b1;
      all_null = 1'b1;
      illegal  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((rails[2*i +: 2] != DR_0) && (rails[2*i +: 2] != DR_1)) begin
            all_data = 1'b0;
         end
         if (rails[2*i +: 2] != DR_NULL) begin
            all_null = 1'b0;
         end
         if (rails[2*i +: 2] == DR_ILL) begin
            illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ncl_alu_stage.sv
// ----------------------------------------------------------------------------
// ncl_alu_stage
// Clocked dual-rail ALU pipeline stage with a four-phase DATA/NULL handshake.
// A complete DATA wavefront on {opr, b, a} is latched (result + flags) when the
// consumer requests DATA; the stage returns to NULL once inputs are NULL and
// the consumer requests NULL. Illegal rail codes are flagged (sticky) and
// block any transition while present.
// Ports:
//   clk     in  1        stage clock
//   rst     in  1        asynchronous active-high reset
//   a, b    in  2*WIDTH  dual-rail operands
//   opr     in  4        dual-rail opcode (ADD/SUB/AND/OR)
//   ack_in  in  1        from consumer: 0 = request DATA, 1 = request NULL
//   ack_out out 1        to producer: 1 = stage holds DATA
//   soma    out 2*WIDTH  dual-rail result
//   zero    out 2        dual-rail flag result == 0
//   neg     out 2        dual-rail flag result MSB
//   of      out 2        dual-rail flag signed overflow (ADD/SUB only)
//   err     out 1        sticky illegal-code indicator
//   tok_cnt out CNT_W    number of DATA wavefronts latched (wraps)
// ----------------------------------------------------------------------------
module ncl_alu_stage
   import ncl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*WIDTH-1:0] a,
   input  logic [2*WIDTH-1:0] b,
   input  logic [3:0]         opr,
   input  logic               ack_in,
   output logic               ack_out,
   output logic [2*WIDTH-1:0] soma,
   output logic [1:0]         zero,
   output logic [1:0]         neg,
   output logic [1:0]         of,
   output logic               err,
   output logic [CNT_W-1:0]   tok_cnt
);

   localparam int NPAIRS = 2 * WIDTH + 2;

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y,
                                    input logic signed [WIDTH-1:0] s);
      return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y,
                                    input logic signed [WIDTH-1:0] s);
      return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
   endfunction

   function automatic logic [1:0] flag_enc(input logic f);
      return f ? DR_1 : DR_0;
   endfunction

   logic all_data;
   logic all_null;
   logic illegal;

   ncl_compl_det #(
      .N (NPAIRS)
   ) u_det (
      .rails    ({opr, b, a}),
      .all_data (all_data),
      .all_null (all_null),
      .illegal  (illegal)
   );

   // ---- stage p0: combinational ALU on the decoded wavefront ----
   dr_rails_t                 a_ext_p0;
   dr_rails_t                 b_ext_p0;
   dr_word_t                  a_w_p0;
   dr_word_t                  b_w_p0;
   dr_word_t                  res_w_p0;
   dr_rails_t                 res_rails_p0;
   logic signed [WIDTH-1:0]   a_p0;
   logic signed [WIDTH-1:0]   b_p0;
   logic signed [WIDTH-1:0]   res_p0;
   logic [1:0]                op_p0;
   logic                      of_p0;
   logic [2*WIDTH-1:0]        soma_p0;
   logic [1:0]                zero_p0;
   logic [1:0]                neg_p0;
   logic [1:0]                of_enc_p0;

   always_comb begin
      a_ext_p0 = '0;
      b_ext_p0 = '0;
      a_ext_p0[2*WIDTH-1:0] = a;
      b_ext_p0[2*WIDTH-1:0] = b;
      a_w_p0 = dr_decode(a_ext_p0);
      b_w_p0 = dr_decode(b_ext_p0);
      a_p0   = signed'(a_w_p0[WIDTH-1:0]);
      b_p0   = signed'(b_w_p0[WIDTH-1:0]);
      // Opcode bit k is carried by pair k; its true rail is the bit value.
      op_p0  = {opr[3], opr[1]};

      res_p0 = '0;
      of_p0  = 1'b0;
      case (op_p0)
         OP_ADD: begin
            res_p0 = a_p0 + b_p0;
            of_p0  = add_ovf(a_p0, b_p0, res_p0);
         end
         OP_SUB: begin
            res_p0 = a_p0 - b_p0;
            of_p0  = sub_ovf(a_p0, b_p0, res_p0);
         end
         OP_AND:  res_p0 = a_p0 & b_p0;
         default: res_p0 = a_p0 | b_p0;
      endcase

      res_w_p0 = '0;
      res_w_p0[WIDTH-1:0] = res_p0;
      res_rails_p0 = dr_encode(res_w_p0);
      soma_p0   = res_rails_p0[2*WIDTH-1:0];
      zero_p0   = flag_enc(res_p0 == '0);
      neg_p0    = flag_enc(res_p0[WIDTH-1]);
      of_enc_p0 = flag_enc(of_p0);
   end

   generate
      if (WIDTH < DR_MAX_W) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^{a_w_p0[DR_MAX_W-1:WIDTH], b_w_p0[DR_MAX_W-1:WIDTH],
                              res_rails_p0[2*DR_MAX_W-1:2*WIDTH]};
      end
   endgenerate

   // ---- handshake FSM: next state and next register contents ----
   state_t             state_q;
   state_t             state_d;
   logic [2*WIDTH-1:0] soma_d;
   logic [1:0]         zero_d;
   logic [1:0]         neg_d;
   logic [1:0]         of_d;
   logic               err_d;
   logic [CNT_W-1:0]   tok_cnt_d;

   always_comb begin
      state_d   = state_q;
      soma_d    = soma;
      zero_d    = zero;
      neg_d     = neg;
      of_d      = of;
      tok_cnt_d = tok_cnt;
      err_d     = err | illegal;
      // An illegal pair freezes the stage for that edge.
      if (!illegal) begin
         case (state_q)
            ST_EMPTY: begin
               if (all_data && !ack_in) begin
                  state_d   = ST_FULL;
                  soma_d    = soma_p0;
                  zero_d    = zero_p0;
                  neg_d     = neg_p0;
                  of_d      = of_enc_p0;
                  tok_cnt_d = tok_cnt + CNT_W'(1);
               end
            end
            default: begin
               if (all_null && ack_in) begin
                  state_d = ST_EMPTY;
                  soma_d  = '0;
                  zero_d  = DR_NULL;
                  neg_d   = DR_NULL;
                  of_d    = DR_NULL;
               end
            end
         endcase
      end
   end

   // ---- stage p1: registered wavefront and control ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         soma    <= '0;
         zero    <= DR_NULL;
         neg     <= DR_NULL;
         of      <= DR_NULL;
         err     <= 1'b0;
         tok_cnt <= '0;
      end else begin
         state_q <= state_d;
         soma    <= soma_d;
         zero    <= zero_d;
         neg     <= neg_d;
         of      <= of_d;
         err     <= err_d;
         tok_cnt <= tok_cnt_d;
      end
   end

   assign ack_out = (state_q == ST_FULL);

endmodule

// File: tb/tb_ncl_alu_stage.sv
// ----------------------------------------------------------------------------
// tb_ncl_alu_stage
// Scoreboard bench for ncl_alu_stage (WIDTH=8, CNT_W=4). Stimulus pushes the
// expected latched wavefront into a queue; a monitor pops and compares each
// time the stage raises ack_out.
// ----------------------------------------------------------------------------
module tb_ncl_alu_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  opr;
   logic        ack_in;
   logic        ack_out;
   logic [15:0] soma;
   logic [1:0]  zero;
   logic [1:0]  neg;
   logic [1:0]  of;
   logic        err;
   logic [3:0]  tok_cnt;

   ncl_alu_stage #(.WIDTH(8), .CNT_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .opr     (opr),
      .ack_in  (ack_in),
      .ack_out (ack_out),
      .soma    (soma),
      .zero    (zero),
      .neg     (neg),
      .of      (of),
      .err     (err),
      .tok_cnt (tok_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       n;
      logic       o;
      logic [3:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cnt_model = 0;
   logic prev_ack = 1'b0;

   function automatic logic [15:0] enc8(input logic [7:0] v);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[2*i+1] = v[i];
         r[2*i]   = ~v[i];
      end
      return r;
   endfunction

   function automatic logic [1:0] encf(input logic f);
      return f ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [3:0] enc_op(input logic [1:0] op);
      return {op[1], ~op[1], op[0], ~op[0]};
   endfunction

   // Reference model: plain integer arithmetic on the logical values.
   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                  input logic [1:0] op, input int cnt);
      exp_t e;
      int sa, sb, s;
      sa = (av > 127) ? int'(av) - 256 : int'(av);
      sb = (bv > 127) ? int'(bv) - 256 : int'(bv);
      s  = 0;
      e.o = 1'b0;
      case (op)
         2'd0: begin s = sa + sb; e.res = 8'((int'(av) + int'(bv)) % 256); e.o = (s > 127) || (s < -128); end
         2'd1: begin s = sa - sb; e.res = 8'((int'(av) - int'(bv) + 256) % 256); e.o = (s > 127) || (s < -128); end
         2'd2: e.res = av & bv;
         default: e.res = av | bv;
      endcase
      e.z   = (e.res == 8'd0);
      e.n   = (e.res >= 8'd128);
      e.cnt = 4'(cnt % 16);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one comparison set per DATA wavefront presented.
   always @(negedge clk) begin
      if (rst) begin
         prev_ack <= 1'b0;
      end else begin
         if (ack_out && !prev_ack) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: soma 0x%0h with empty scoreboard", soma);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_soma", 32'(soma), 32'(enc8(e.res)));
               chk("sb_zero", 32'(zero), 32'(encf(e.z)));
               chk("sb_neg", 32'(neg), 32'(encf(e.n)));
               chk("sb_of", 32'(of), 32'(encf(e.o)));
               chk("sb_tok_cnt", 32'(tok_cnt), 32'(e.cnt));
            end
         end
         prev_ack <= ack_out;
      end
   end

   task automatic drive_data(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] op);
      a   = enc8(av);
      b   = enc8(bv);
      opr = enc_op(op);
   endtask

   task automatic drive_null();
      a   = '0;
      b   = '0;
      opr = '0;
   endtask

   task automatic push(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] op);
      cnt_model++;
      exp_q.push_back(model(av, bv, op, cnt_model));
   endtask

   task automatic release_stage();
      @(negedge clk);
      drive_null();
      ack_in = 1'b1;
      @(posedge clk);
      #1;
      chk("release_ack", 32'(ack_out), 32'd0);
      chk("release_null", 32'({soma, zero, neg, of}), 32'd0);
   endtask

   task automatic txn(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] op);
      @(negedge clk);
      drive_data(av, bv, op);
      ack_in = 1'b0;
      push(av, bv, op);
      @(posedge clk);
      #1;
      chk("latch_ack", 32'(ack_out), 32'd1);
      release_stage();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_ack", 32'(ack_out), 32'd0);
      chk("rst_rails", 32'({soma, zero, neg, of}), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cnt", 32'(tok_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cnt_model = 0;
   endtask

   initial begin
      logic [15:0] part;
      exp_t        e;
      rst    = 1'b1;
      ack_in = 1'b0;
      drive_null();
      #12;
      chk("init_ack", 32'(ack_out), 32'd0);
      chk("init_rails", 32'({soma, zero, neg, of}), 32'd0);
      chk("init_err", 32'(err), 32'd0);
      chk("init_cnt", 32'(tok_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed ALU cases
      txn(8'h7F, 8'h01, 2'd0);
      txn(8'h05, 8'h05, 2'd1);
      txn(8'hF0, 8'h3C, 2'd2);
      txn(8'h80, 8'h01, 2'd3);
      txn(8'h80, 8'h01, 2'd1);
      txn(8'h80, 8'h80, 2'd0);

      // Randomized operations
      for (int i = 0; i < 14; i++) begin
         txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      end

      // Partial wavefront: b pair 0 left NULL
      @(negedge clk);
      part = enc8(8'h33);
      part[1:0] = 2'b00;
      a = enc8(8'h12);
      b = part;
      opr = enc_op(2'd0);
      ack_in = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("partial_ack", 32'(ack_out), 32'd0);
      chk("partial_cnt", 32'(tok_cnt), 32'(cnt_model % 16));
      @(negedge clk);
      b = enc8(8'h33);
      push(8'h12, 8'h33, 2'd0);
      @(posedge clk);
      #1;
      chk("partial_done_ack", 32'(ack_out), 32'd1);
      release_stage();

      // Complete DATA but consumer still requests NULL
      @(negedge clk);
      drive_data(8'h9C, 8'h27, 2'd1);
      ack_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("ackin_hold", 32'(ack_out), 32'd0);
      @(negedge clk);
      ack_in = 1'b0;
      push(8'h9C, 8'h27, 2'd1);
      e = model(8'h9C, 8'h27, 2'd1, cnt_model);
      @(posedge clk);
      #1;
      chk("ackin_latch", 32'(ack_out), 32'd1);
      // FULL: NULL inputs without ack_in, then new DATA -> nothing moves
      @(negedge clk);
      drive_null();
      repeat (3) @(posedge clk);
      #1;
      chk("full_hold_ack", 32'(ack_out), 32'd1);
      chk("full_hold_soma", 32'(soma), 32'(enc8(e.res)));
      @(negedge clk);
      drive_data(8'h01, 8'h02, 2'd3);
      repeat (2) @(posedge clk);
      #1;
      chk("full_inchg_soma", 32'(soma), 32'(enc8(e.res)));
      chk("full_inchg_cnt", 32'(tok_cnt), 32'(cnt_model % 16));
      release_stage();

      // Illegal pair on a[3]
      @(negedge clk);
      part = enc8(8'h44);
      part[7:6] = 2'b11;
      a = part;
      b = enc8(8'h11);
      opr = enc_op(2'd0);
      ack_in = 1'b0;
      @(posedge clk);
      #1;
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_nolatch", 32'(ack_out), 32'd0);
      @(negedge clk);
      a = enc8(8'h44);
      push(8'h44, 8'h11, 2'd0);
      @(posedge clk);
      #1;
      chk("illegal_resume", 32'(ack_out), 32'd1);
      chk("illegal_sticky", 32'(err), 32'd1);
      release_stage();
      chk("illegal_sticky2", 32'(err), 32'd1);

      // Counter wrap from reset
      do_reset();
      for (int i = 0; i < 17; i++) begin
         txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      end
      chk("wrap_cnt", 32'(tok_cnt), 32'd1);

      // Asynchronous reset while FULL (not sent through the scoreboard:
      // reset lands before the monitor's sampling edge)
      @(negedge clk);
      drive_data(8'h55, 8'hAA, 2'd3);
      ack_in = 1'b0;
      e = model(8'h55, 8'hAA, 2'd3, cnt_model + 1);
      @(posedge clk);
      #1;
      chk("pre_rst_ack", 32'(ack_out), 32'd1);
      chk("pre_rst_soma", 32'(soma), 32'(enc8(e.res)));
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ack", 32'(ack_out), 32'd0);
      chk("async_rst_rails", 32'({soma, zero, neg, of}), 32'd0);
      chk("async_rst_cnt", 32'(tok_cnt), 32'd0);
      @(negedge clk);
      drive_null();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ncl_alu_stage.md
Name: ncl_alu_stage

Overview:
- Clocked, parametrised dual-rail ALU pipeline stage.
- Takes dual-rail operands and an opcode, computes a result plus zero/neg/overflow flags, and registers them under a four-phase DATA/NULL handshake.
- Adds to the previous stage: generic width, an explicit phase FSM, illegal-code detection and a wavefront counter.
- Sits between dual-rail producer/consumer stages in the ULA datapath; one clock, rail pairs packed as [2i+1]=true rail, [2i]=false rail.

Parameters:
- WIDTH, 8, logical operand/result bits (each carried on 2 rails).
- CNT_W, 8, width of the DATA-wavefront counter.

Ports:
- clk  in  1  stage clock.
- rst  in  1  reset; asynchronous, active-high.
- a  in  2*WIDTH  dual-rail operand A.
- b  in  2*WIDTH  dual-rail operand B.
- opr  in  4  dual-rail opcode, 2 logical bits.
- ack_in  in  1  from downstream; 0 = request-for-DATA, 1 = request-for-NULL.
- ack_out  out  1  to upstream; 1 = stage holds DATA (request-for-NULL), 0 = stage holds NULL.
- soma  out  2*WIDTH  dual-rail result.
- zero  out  2  dual-rail flag: result == 0.
- neg  out  2  dual-rail flag: result MSB.
- of  out  2  dual-rail flag: signed overflow.
- err  out  1  sticky: illegal rail code seen.
- tok_cnt  out  CNT_W  count of DATA wavefronts latched.

Behaviour:
- Rail pair codes: 00 = NULL, 01 = logical 0, 10 = logical 1, 11 = illegal.
- in_data: every pair of a, b and opr is 01 or 10. in_null: every pair is 00.
- Reset (async, immediate): state EMPTY; all rails of soma/zero/neg/of = 0 (NULL); ack_out=0; err=0; tok_cnt=0. Asserting rst mid-handshake discards the held wavefront.
- FSM, two states, one transition per clock edge at most:
  - EMPTY (ack_out=0, outputs NULL): if in_data && !ack_in && !illegal, latch the ALU result, tok_cnt+1, go to FULL. Otherwise hold.
  - FULL (ack_out=1, outputs DATA): if in_null && ack_in, drive all output rails to 0, go to EMPTY. Otherwise hold the registered DATA unchanged.
- Latency: 1 clock from the enabling condition to registered outputs and ack_out.
- Partial wavefronts (a mix of NULL and valid pairs): no transition; outputs are held.
- EMPTY with complete DATA but ack_in=1: no latch, waits for ack_in=0. FULL with NULL but ack_in=0: no release.
- Inputs changing while FULL do not disturb the outputs.
- Opcode: 00 ADD (a+b mod 2^WIDTH), 01 SUB (a-b mod 2^WIDTH), 10 AND, 11 OR.
- Flags:
  - of = signed overflow for ADD/SUB; 0 for AND/OR.
  - zero = (res==0).
  - neg = res[WIDTH-1].
  - Each flag is encoded dual-rail (1 -> 10, 0 -> 01).
- Illegal: any input pair = 11 while in EMPTY or FULL sets err=1 on the next edge. err stays set until rst. The state is held that edge (no latch, no release). Once the pair clears, normal operation resumes and err remains 1.
- tok_cnt wraps from 2^CNT_W-1 to 0.
- Simultaneous latch condition and rst: rst wins.

Decomposition:
- Shared package ncl_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3;
  - rail codes DR_NULL=2'b00, DR_0=2'b01, DR_1=2'b10;
  - state encoding ST_EMPTY/ST_FULL;
  - helper functions for dual-rail encode/decode of a vector.
- Sub-module ncl_compl_det(N): over 2*N rails, outputs all_data, all_null and illegal. It is instantiated once over the concatenation {opr, b, a}.
- The ALU core stays inline in the stage.

Test Plan:
- WIDTH=8, ack_in=0, ADD a=0x7F, b=0x01 -> next edge soma=0x80 dual-rail, of=10, neg=10, zero=01, ack_out=1, tok_cnt=1. Then drive NULL inputs with ack_in=1 -> next edge all rails 0, ack_out=0.
- SUB a=0x05, b=0x05 -> soma=0x00, zero=10, neg=01, of=01. AND 0xF0 & 0x3C -> 0x30. OR 0x80 | 0x01 -> 0x81, neg=10.
- b[0] left NULL, rest DATA, held 10 cycles -> ack_out stays 0. Complete b[0] -> latch on the following edge.
- Complete DATA with ack_in=1 held 5 cycles -> no latch. Drop ack_in -> latch on the next edge. Also, in FULL, NULL inputs with ack_in=0 -> no release.
- Pair 11 on a[3] in EMPTY -> err=1 next edge, no latch. Restore a legal code -> latch proceeds, err stays 1 until rst.
- CNT_W=4, 17 full DATA/NULL cycles -> tok_cnt=1 (wrapped). rst asserted while FULL -> ack_out=0, outputs NULL and tok_cnt=0 immediately, without waiting for clk.
